// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_pkg;

  // Register index width of the RV32I register file.
  localparam int REG_IDX_W = 5;

  // Sequencer states: normal flow, data access stall, discard of one stale fetch.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DROP  = 2'd2
  } pctrl_state_t;

  // Control pair for one pipeline register.
  typedef struct packed {
    logic en;
    logic flush;
  } pipe_ctl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step by one unless already at the all-ones ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline. Control outputs are
// combinational from the registered state and the current hazard inputs.
module pipe_ctrl #(
  parameter int CNT_W     = 32,
  parameter int REG_IDX_W = pipe_pkg::REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_redirect,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 pc_en,
  output logic                 en_if_id,
  output logic                 en_id_ex,
  output logic                 en_ex_mem,
  output logic                 en_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 flush_mem_wb,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  import pipe_pkg::*;

  pctrl_state_t state_q;
  pctrl_state_t state_d;
  pipe_ctl_t    if_id_s;
  pipe_ctl_t    id_ex_s;
  pipe_ctl_t    ex_mem_s;
  pipe_ctl_t    mem_wb_s;
  logic         pc_en_s;
  logic         imem_req_s;
  logic         load_use_s;
  logic         dstall_s;
  logic         any_flush_s;

  // x0 is never a real producer, and rs2 only matters when the ID instruction reads it.
  assign load_use_s = ex_is_load && (ex_rd != {REG_IDX_W{1'b0}}) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign dstall_s   = dmem_req && !dmem_ready;

  // Hazard resolution: reset > data wait > redirect > load-use > fetch wait / stale drop.
  always_comb begin
    state_d    = RUN;
    if_id_s    = '{en: 1'b1, flush: 1'b0};
    id_ex_s    = '{en: 1'b1, flush: 1'b0};
    ex_mem_s   = '{en: 1'b1, flush: 1'b0};
    mem_wb_s   = '{en: 1'b1, flush: 1'b0};
    pc_en_s    = 1'b1;
    imem_req_s = 1'b1;
    if (rst) begin
      if_id_s    = '{en: 1'b0, flush: 1'b1};
      id_ex_s    = '{en: 1'b0, flush: 1'b1};
      ex_mem_s   = '{en: 1'b0, flush: 1'b1};
      mem_wb_s   = '{en: 1'b0, flush: 1'b1};
      pc_en_s    = 1'b0;
      imem_req_s = 1'b0;
      state_d    = RUN;
    end else if (dstall_s) begin
      // Freeze everything; a pending redirect stays in EX until the access completes.
      if_id_s.en  = 1'b0;
      id_ex_s.en  = 1'b0;
      ex_mem_s.en = 1'b0;
      mem_wb_s.en = 1'b0;
      pc_en_s     = 1'b0;
      imem_req_s  = 1'b0;
      state_d     = DWAIT;
    end else if (ex_redirect) begin
      // Redirect squashes the younger IF and ID instructions; a miss means a stale word is coming.
      if_id_s.flush = 1'b1;
      id_ex_s.flush = 1'b1;
      state_d       = imem_ready ? RUN : DROP;
    end else begin
      // In DROP the first returning word is the stale one, so it is treated like a fetch wait.
      state_d = ((state_q == DROP) && !imem_ready) ? DROP : RUN;
      if (load_use_s) begin
        pc_en_s       = 1'b0;
        if_id_s.en    = 1'b0;
        id_ex_s.flush = 1'b1;
      end else if ((state_q == DROP) || !imem_ready) begin
        pc_en_s       = 1'b0;
        if_id_s.flush = 1'b1;
      end else begin
        pc_en_s = 1'b1;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign any_flush_s = if_id_s.flush || id_ex_s.flush || ex_mem_s.flush || mem_wb_s.flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_en_s),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (any_flush_s && !rst),
    .count (flush_cnt)
  );

  assign imem_req     = imem_req_s;
  assign pc_en        = pc_en_s;
  assign en_if_id     = if_id_s.en;
  assign en_id_ex     = id_ex_s.en;
  assign en_ex_mem    = ex_mem_s.en;
  assign en_mem_wb    = mem_wb_s.en;
  assign flush_if_id  = if_id_s.flush;
  assign flush_id_ex  = id_ex_s.flush;
  assign flush_ex_mem = ex_mem_s.flush;
  assign flush_mem_wb = mem_wb_s.flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs2, ex_is_load, ex_redirect;
  logic          dmem_req, dmem_ready, imem_req, imem_ready, pc_en;
  logic          en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic          flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int nvec = 0;
  int nerr = 0;

  // Reference model state.
  bit stale_pending = 1'b0;
  int stall_m = 0;
  int flush_m = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW), .REG_IDX_W(5)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_req(imem_req), .imem_ready(imem_ready),
    .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
    .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational controls, clock, check counters.
  task automatic step(input string tag, input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u2, input logic [4:0] rd, input bit ld, input bit redir,
                      input bit dreq, input bit drdy, input bit irdy);
    bit lu, dst;
    bit e_req, e_pc;
    bit [3:0] e_en, e_fl;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_rd = rd;
    ex_is_load = ld; ex_redirect = redir; dmem_req = dreq; dmem_ready = drdy; imem_ready = irdy;
    #2;
    lu  = ld && (rd != 5'd0) && ((rd == rs1) || (u2 && (rd == rs2)));
    dst = dreq && !drdy;
    e_req = 1'b1; e_pc = 1'b1; e_en = 4'b1111; e_fl = 4'b0000;
    if (r) begin
      e_req = 1'b0; e_pc = 1'b0; e_en = 4'b0000; e_fl = 4'b1111;
    end else if (dst) begin
      e_req = 1'b0; e_pc = 1'b0; e_en = 4'b0000;
    end else if (redir) begin
      e_fl = 4'b1100;
    end else if (lu) begin
      e_pc = 1'b0; e_en = 4'b0111; e_fl = 4'b0100;
    end else if (stale_pending || !irdy) begin
      e_pc = 1'b0; e_fl = 4'b1000;
    end
    chk({tag, ".ctl"},
        {22'd0, imem_req, pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
         flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb},
        {22'd0, e_req, e_pc, e_en, e_fl});
    @(posedge clk);
    if (r) begin
      stall_m = 0; flush_m = 0; stale_pending = 1'b0;
    end else begin
      if (!e_pc && stall_m < CMAX) stall_m++;
      if ((e_fl != 4'b0000) && flush_m < CMAX) flush_m++;
      if (dst) stale_pending = 1'b0;
      else if (redir) stale_pending = !irdy;
      else stale_pending = stale_pending && !irdy;
    end
    #1;
    chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, stall_m);
    chk({tag, ".flush_cnt"}, {28'd0, flush_cnt}, flush_m);
  endtask

  initial begin
    // Reset held for two cycles, then a clean advancing cycle.
    step("rst0", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
    step("rst1", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
    step("run0", 0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1);
    // Load-use on rs1: one bubble cycle, then flow resumes.
    step("lu_rs1", 0, 5'd5, 5'd1, 1, 5'd5, 1, 0, 0, 0, 1);
    step("lu_after", 0, 5'd6, 5'd1, 1, 5'd7, 0, 0, 0, 0, 1);
    // x0 producer and unused rs2 match never stall; used rs2 match does.
    step("lu_x0", 0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, 1);
    step("lu_rs2_unused", 0, 5'd1, 5'd9, 0, 5'd9, 1, 0, 0, 0, 1);
    step("lu_rs2_used", 0, 5'd1, 5'd9, 1, 5'd9, 1, 0, 0, 0, 1);
    // Data wait for three cycles with a held redirect, applied on completion.
    for (int i = 0; i < 3; i++) step("dwait", 0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 1, 0, 1);
    step("dwait_done", 0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 1, 1, 1);
    // Redirect with fetch in flight: stale word dropped, next word accepted.
    step("redir_miss", 0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, 0);
    step("drop_wait", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);
    step("drop_stale", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
    step("drop_target", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
    // Redirect beats load-use in the same cycle.
    step("redir_lu", 0, 5'd4, 5'd2, 0, 5'd4, 1, 1, 0, 0, 1);
    // Long fetch wait saturates the stall counter.
    for (int i = 0; i < 20; i++) step("sat", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);
    step("sat_end", 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
    // Reset mid-operation clears counters, then randomized traffic.
    step("rst_mid", 1, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 63) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
